// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register pair in front of a
// small byte FIFO that feeds a start/data/stop serializer on tx.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bitidx;
  logic [7:0]      shifter;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            overflow;

  logic            full;
  logic            empty;
  logic            busy;
  logic            baud_done;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            clr_ovf;
  logic [31:0]     status;

  always_comb begin
    sel       = (a[31:3] == BASE_ADDR[31:3]);
    full      = (count == DEPTH_C);
    empty     = (count == '0);
    busy      = (state != IDLE);
    baud_done = (baud == BAUD_LAST);
    push_req  = we & sel & ~a[2];
    clr_ovf   = we & sel & a[2];
    // Full is judged on the pre-edge count, so a push racing a pop while full is still dropped.
    push      = push_req & ~full;
    pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
  end

  always_comb begin
    status            = '0;
    status[0]         = full;
    status[1]         = empty;
    status[2]         = busy;
    status[3]         = overflow;
    status[8 +: CW]   = count;
    rd                = (sel & a[2]) ? status : '0;
  end

  // FIFO storage and shift register carry data only; they need no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wd[7:0];
    if (pop)
      shifter <= mem[rptr];
    else if ((state == DATA) && baud_done)
      shifter <= shifter >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req & full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      baud   <= '0;
      bitidx <= '0;
      tx     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (!empty) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state  <= DATA;
            baud   <= '0;
            bitidx <= '0;
            tx     <= shifter[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bitidx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitidx <= bitidx + 3'd1;
              tx     <= shifter[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            // Chain straight into the next frame when a byte is waiting.
            if (!empty) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          baud  <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data bus, downstream of the core's store path next to `dmem`. It consumes `MemWrite`/`DataAdr`/`WriteData` stores that hit its address window and buffers bytes in a small FIFO. It serializes each byte as an 8N1 frame on `tx`. It also returns a status word that `top` muxes onto `ReadData` when `sel` is high.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; a power of 2 in the range 2..8.
- `BASE_ADDR`, default 32'h0000_0400: window base; 8-byte aligned; sits above the 1 KiB `dmem`.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `we` in 1: bus write strobe; `MemWrite` from the core.
- `a` in 32: bus byte address; `DataAdr`.
- `wd` in 32: bus write data; `WriteData`.
- `rd` out 32: combinational read data.
- `sel` out 1: combinational address hit. `top` uses it to select `rd` over `dmem` and to gate `dmem` `we`.
- `tx` out 1: serial output, registered, idles high.

## Operation
- Address decode: `sel = (a[31:3] == BASE_ADDR[31:3])`.
  - TXDATA is at `BASE_ADDR+0` (`a[2]=0`).
  - STATUS is at `BASE_ADDR+4` (`a[2]=1`).
- Write TXDATA (`we & sel & ~a[2]`):
  - If the FIFO is not full, push `wd[7:0]`. Upper bits are ignored.
  - If the FIFO is full, drop the byte and set sticky `overflow`.
- Write STATUS (`we & sel & a[2]`): clears `overflow`; the data value is ignored.
- Read data:
  - `sel & a[2]`: `rd` returns STATUS.
  - `sel & ~a[2]`: `rd` returns 0.
  - `~sel`: `rd` = 0.
- STATUS word:
  - [0] full
  - [1] empty
  - [2] busy (state ≠ IDLE)
  - [3] overflow
  - [11:8] count (0..FIFO_DEPTH)
  - all other bits 0
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. The count is width log2(FIFO_DEPTH)+1.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop into an 8-bit shifter and go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx = shifter[0]`, LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles. At expiry, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reset on every state or bit change.

## Timing
- Reset (async, immediate) sets:
  - `tx=1`
  - state IDLE
  - FIFO empty; pointers and count 0
  - `overflow=0`
  - STATUS reads 32'h0000_0002
- Push takes effect at the rising edge where the write strobe is sampled.
- Earliest pop is the next edge, so latency from the write edge to the first `tx=0` cycle is 1 cycle (store edge + 1 edge).
- A frame is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- Full check:
  - Full is evaluated on the pre-edge count.
  - A push in the same cycle as a pop while full is dropped and sets `overflow`.
  - Count after that edge = DEPTH−1.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- There is no write-through when empty. A byte pushed into an empty FIFO while IDLE is popped at the following edge.
- Reset asserted mid-frame: the frame is aborted, `tx` goes high immediately, and FIFO contents are discarded.
- `rd` and `sel` are purely combinational from `a` and current state. They have no clock latency, matching `dmem` read timing.

## Test plan
All tests use CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x400.

- **Reset:** assert reset → `tx=1`. Read 0x404 → `rd=0x0000_0002`. Read 0x400 → 0. Read 0x060 → `sel=0`, `rd=0`.
- **Single byte:** store 0x55 to 0x400 → starting 1 cycle after the store edge, `tx` follows 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each level exactly 4 cycles (40 total). Busy=1 throughout; STATUS=0x002 afterwards.
- **Overflow:** six consecutive stores 0x01..0x06 to 0x400 on consecutive cycles:
  - 0x01 is popped; 0x02–0x05 fill the FIFO; 0x06 is dropped.
  - STATUS=0x0000_040D.
  - Serial output is 0x01..0x05 only.
- **Overflow clear:** after the overflow scenario, store any value to 0x404 → bit 3 clears; STATUS=0x0000_0405 while the frames are still pending.
- **Back-to-back:** stores 0xA5, 0x3C → 80 continuous cycles of frames. Between the frames, stop-bit `tx=1` lasts exactly 4 cycles, followed immediately by the second start bit.
- **Reset mid-frame and decode isolation:**
  - Assert reset at cycle 10 of a frame with 2 bytes queued → `tx=1` at once. After release, STATUS=0x002 and no further frames are sent.
  - A store to 0x060 → `sel=0`; FIFO and `tx` are unaffected.
